riscv_fetch_queue: RTL and testbench
====================================

RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address and PC width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; a power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready  input  1  instruction memory accepts the request.
REQ-008 SHALL have port imem_req_addr  output  XLEN  fetch address, bits [1:0] always 0.
REQ-009 SHALL have port imem_rsp_valid  input  1  response valid; responses arrive in request order, at least 1 cycle after acceptance.
REQ-010 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump redirect from the execute stage.
REQ-012 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-013 SHALL have port instr_valid  output  1  decode-side instruction valid.
REQ-014 SHALL have port instr_ready  input  1  decode stage accepts the instruction (low means stall).
REQ-015 SHALL have port instr  output  32  queued instruction word.
REQ-016 SHALL have port pc  output  XLEN  address of instr.
REQ-017 SHALL have port occupancy  output  log2(DEPTH)+1  number of valid queue entries.

Function
REQ-018 SHALL hold fetch_pc, a DEPTH-entry FIFO of {pc, instr}, an outstanding-request counter and a discard counter.
REQ-019 SHALL assert imem_req_valid when occupancy + outstanding < DEPTH and redirect_valid is low, driving imem_req_addr = fetch_pc.
REQ-020 SHALL advance fetch_pc by 4 on each accepted request (valid and ready), with modulo-2^XLEN wrap.
REQ-021 SHALL count an outstanding request on acceptance and retire it on imem_rsp_valid; a simultaneous accept and response leaves the count unchanged.
REQ-022 SHALL write a non-discarded response into the FIFO tail, tagged with its request address.
REQ-023 SHALL present the FIFO head on instr/pc with instr_valid = (occupancy != 0), and pop on instr_valid and instr_ready.
REQ-024 SHALL never overflow: the credit rule in REQ-019 guarantees space for every outstanding response.
REQ-025 SHALL support a simultaneous push and pop with occupancy unchanged, including when full, and wrap FIFO pointers modulo DEPTH.
REQ-026 SHALL, on redirect_valid, empty the FIFO in the same cycle, load fetch_pc with {redirect_pc[XLEN-1:2], 2'b00}, move the outstanding count (net of any same-cycle response) into the discard counter, and suppress the pop.
REQ-027 SHALL drop responses while the discard counter is non-zero, decrementing it by one per response.
REQ-028 SHALL give redirect priority over push, pop and request in the same cycle; instr_valid is 0 in the following cycle.
REQ-029 SHALL hold all outputs stable while instr_valid=1 and instr_ready=0.

Reset
REQ-030 SHALL, while rst=0 at a clock edge, set fetch_pc=RESET_PC, FIFO pointers, occupancy, outstanding and discard to 0.
REQ-031 SHALL hold imem_req_valid=0 and instr_valid=0 in reset; instr, pc and imem_req_addr read 0 while instr_valid=0.
REQ-032 SHALL abandon in-flight requests on reset mid-operation; the memory is reset with the block.

Configuration
REQ-033 SHALL provide macro RISCV_FETCH_BYPASS_EN.
REQ-034 SHALL, when the macro is defined, pass a non-discarded response combinationally to instr/pc while the FIFO is empty; with instr_ready=1 it is consumed without being written.
REQ-035 SHALL, when the macro is undefined, register every response through the FIFO, giving 1 cycle of response-to-instr_valid latency.

Verification
REQ-036 SHALL cover reset release with RESET_PC=0x100 and ready tied high: imem_req_addr sequence 0x100,0x104,0x108,... and instr/pc pairs delivered in order.
REQ-037 SHALL cover instr_ready=0 for 10 cycles with DEPTH=4: occupancy saturates at 4, imem_req_valid drops, and no entry is lost or duplicated.
REQ-038 SHALL cover redirect_valid with redirect_pc=0x2003 and 2 requests outstanding: the next request address is 0x2000, both stale responses are dropped, and the first pc delivered is 0x2000.
REQ-039 SHALL cover a redirect coinciding with a push and a pop: occupancy becomes 0 and instr_valid=0 on the next cycle.
REQ-040 SHALL cover fetch_pc=0xFFFFFFFC with XLEN=32: the following request address is 0x00000000.
REQ-041 SHALL cover bypass latency: with RISCV_FETCH_BYPASS_EN defined and the FIFO empty, instr_valid rises in the response cycle; without the macro it rises 1 cycle later.

Source files
------------

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: in-order instruction fetch with credit-based request issue, FIFO and redirect flush
//   Optional macro: RISCV_FETCH_BYPASS_EN (a response passes straight to decode while the FIFO is empty)
//   Ports:
//     clk, rst (synchronous, active-low)
//     imem_req_valid/imem_req_ready/imem_req_addr : fetch request channel
//     imem_rsp_valid/imem_rsp_data                : in-order response channel
//     redirect_valid/redirect_pc                  : flush and refetch from a new target
//     instr_valid/instr_ready/instr/pc            : decode-side instruction stream
//     occupancy                                   : valid FIFO entries
module riscv_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [XLEN-1:0]              imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [31:0]                  imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [31:0]                  instr,
  output logic [XLEN-1:0]              pc,
  output logic [$clog2(DEPTH):0]       occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 16;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
  logic [XLEN-1:0] fetch_pc, rsp_pc, target;
  logic [31:0] fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding;
  logic [DW-1:0] discard;
  logic has_head, rsp_keep, bypass, accept, push, fifo_pop;
  assign target = redirect_pc & ALIGN;
  assign has_head = count != '0;
  // Responses are in order, so rsp_pc tracks the address of the next non-discarded response.
  assign rsp_keep = imem_rsp_valid && discard == '0;
`ifdef RISCV_FETCH_BYPASS_EN
  assign bypass = rst && rsp_keep && !has_head && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif
  // Credit: every in-flight live request is guaranteed a FIFO slot.
  assign imem_req_valid = rst && !redirect_valid && ({1'b0, count} + {1'b0, outstanding} < CAP);
  assign imem_req_addr = imem_req_valid ? fetch_pc : '0;
  assign accept = imem_req_valid && imem_req_ready;
  assign instr_valid = rst && (has_head || bypass);
  assign instr = !instr_valid ? '0 : has_head ? fifo_instr[rd_ptr] : imem_rsp_data;
  assign pc = !instr_valid ? '0 : has_head ? fifo_pc[rd_ptr] : rsp_pc;
  assign occupancy = count;
  assign fifo_pop = rst && has_head && instr_ready && !redirect_valid;
  assign push = rsp_keep && !redirect_valid && !(bypass && instr_ready);
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC & ALIGN;
      rsp_pc <= RESET_PC & ALIGN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      outstanding <= '0;
      discard <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= target;
      rsp_pc <= target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      outstanding <= '0;
      // Everything still in flight (live or already stale) is now stale; a same-cycle response retires one.
      discard <= discard + DW'(outstanding) - DW'(imem_rsp_valid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + XLEN'(4);
      if (rsp_keep) rsp_pc <= rsp_pc + XLEN'(4);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(fifo_pop);
      outstanding <= outstanding + CW'(accept) - CW'(rsp_keep);
      if (imem_rsp_valid && !rsp_keep) discard <= discard - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr] <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb_riscv_fetch_queue: directed table-driven bench with an in-order instruction memory model
module tb_riscv_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr, pc;
  logic [2:0] occupancy;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem_q [$];
  riscv_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, rdy, rdr;
    logic [31:0] rdr_pc;
    logic iready, rsp_en;
    logic ereq;
    logic [31:0] eaddr;
    logic eiv;
    logic [31:0] epc;
    logic [2:0] eocc;
  } vec_t;
  vec_t vecs [$];
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  function automatic vec_t mk(input logic r, rdy, rdr, input logic [31:0] rdr_pc, input logic iready, rsp_en,
                              input logic ereq, input logic [31:0] eaddr, input logic eiv,
                              input logic [31:0] epc, input logic [2:0] eocc);
    vec_t v;
    v.r = r; v.rdy = rdy; v.rdr = rdr; v.rdr_pc = rdr_pc; v.iready = iready; v.rsp_en = rsp_en;
    v.ereq = ereq; v.eaddr = eaddr; v.eiv = eiv; v.epc = epc; v.eocc = eocc;
    return v;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, rdy, rdr, input logic [31:0] rdr_pc, input logic iready, rsp_en);
    @(negedge clk);
    rst = r;
    imem_req_ready = rdy;
    redirect_valid = rdr;
    redirect_pc = rdr_pc;
    instr_ready = iready;
    imem_rsp_valid = rsp_en && mem_q.size() > 0;
    imem_rsp_data = imem_rsp_valid ? word_at(mem_q[0]) : 32'h0;
    #1;
  endtask
  // Memory bookkeeping for the handshakes seen this cycle; the next response is offered no earlier than next cycle.
  task automatic settle();
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
    if (!rst) mem_q.delete();
  endtask
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    vecs.push_back(mk(0,1,0,0,1,0, 0,32'h0,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h100,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h104,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h108,1,32'h100,1));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h10C,1,32'h104,1));
    vecs.push_back(mk(1,1,0,0,0,1, 1,32'h110,1,32'h108,1));
    vecs.push_back(mk(1,1,0,0,0,1, 1,32'h114,1,32'h108,2));
    vecs.push_back(mk(1,1,0,0,0,1, 0,32'h0,1,32'h108,3));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1,1,0,0,0,1, 0,32'h0,1,32'h108,4));
    vecs.push_back(mk(1,1,0,0,1,1, 0,32'h0,1,32'h108,4));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h118,1,32'h10C,3));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h11C,1,32'h110,2));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h120,1,32'h114,2));
    vecs.push_back(mk(1,1,0,0,0,0, 1,32'h124,1,32'h118,2));
    vecs.push_back(mk(1,1,1,32'h2003,1,0, 0,32'h0,1,32'h118,2));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h2000,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h2004,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h2008,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h200C,1,32'h2000,1));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h2010,1,32'h2004,1));
    vecs.push_back(mk(1,1,1,32'h3000,1,1, 0,32'h0,1,32'h2008,1));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h3000,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h3004,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h3008,1,32'h3000,1));
    vecs.push_back(mk(1,1,1,32'hFFFF_FFF8,1,1, 0,32'h0,1,32'h3004,1));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'hFFFF_FFF8,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'hFFFF_FFFC,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h0,1,32'hFFFF_FFF8,1));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h4,1,32'hFFFF_FFFC,1));
    vecs.push_back(mk(0,1,0,0,1,0, 0,32'h0,0,32'h0,1));
    vecs.push_back(mk(0,1,0,0,1,0, 0,32'h0,0,32'h0,0));
    vecs.push_back(mk(1,1,0,0,1,1, 1,32'h100,0,32'h0,0));
    drive(0,1,0,0,1,0);
    settle();
    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].rdy, vecs[k].rdr, vecs[k].rdr_pc, vecs[k].iready, vecs[k].rsp_en);
      check($sformatf("row%0d req_valid", k), 32'(imem_req_valid), 32'(vecs[k].ereq));
      check($sformatf("row%0d req_addr", k), imem_req_addr, vecs[k].eaddr);
      check($sformatf("row%0d instr_valid", k), 32'(instr_valid), 32'(vecs[k].eiv));
      check($sformatf("row%0d pc", k), pc, vecs[k].epc);
      check($sformatf("row%0d instr", k), instr, vecs[k].eiv ? word_at(vecs[k].epc) : 32'h0);
      check($sformatf("row%0d occupancy", k), 32'(occupancy), 32'(vecs[k].eocc));
      settle();
    end
    // Response-to-instr_valid latency with an empty FIFO; 0x100 is in flight from the last row.
    drive(1,1,0,0,1,1);
    check("lat_rsp_present", 32'(imem_rsp_valid), 32'h1);
`ifdef RISCV_FETCH_BYPASS_EN
    check("lat_iv_rsp_cycle", 32'(instr_valid), 32'h1);
    check("lat_pc_rsp_cycle", pc, 32'h100);
    check("lat_instr_rsp_cycle", instr, word_at(32'h100));
`else
    check("lat_iv_rsp_cycle", 32'(instr_valid), 32'h0);
    check("lat_pc_rsp_cycle", pc, 32'h0);
`endif
    settle();
    drive(1,1,0,0,1,1);
    check("lat_iv_next", 32'(instr_valid), 32'h1);
`ifdef RISCV_FETCH_BYPASS_EN
    check("lat_pc_next", pc, 32'h104);
`else
    check("lat_pc_next", pc, 32'h100);
`endif
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
